// File: rtl/pc_pkg.sv
// Shared op-code definitions for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned PC_OP_W = 3;

  localparam logic [PC_OP_W-1:0] PC_HOLD   = 3'd0;
  localparam logic [PC_OP_W-1:0] PC_INC    = 3'd1;
  localparam logic [PC_OP_W-1:0] PC_JMP    = 3'd2;
  localparam logic [PC_OP_W-1:0] PC_BR_REL = 3'd3;
  localparam logic [PC_OP_W-1:0] PC_CALL   = 3'd4;
  localparam logic [PC_OP_W-1:0] PC_RET    = 3'd5;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack with occupancy pointer.
// Ports: clk, rst (sync active-high), push/pop requests, din (pushed value),
//        dout (current top of stack), sp (occupancy 0..DEPTH), full, empty.
// A push while full and a pop while empty are ignored.
module pc_return_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top_idx;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = PTR_W'(sp - SP_W'(1));
  assign dout    = mem[top_idx];

  // Occupancy pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Storage is never cleared; only the pointer defines validity
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[sp[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: increment, jump, relative branch, call/return.
// Ports: clk, rst (sync active-high), pc_enable (apply op), op, cond (branch
//        condition), bus (target/offset); out (PC), sp (stack occupancy),
//        stack_full/stack_empty (from sp), overflow/underflow (sticky errors).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = 16,
  parameter int unsigned       STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pc_enable,
  input  logic [PC_OP_W-1:0]            op,
  input  logic                          cond,
  input  logic [WIDTH-1:0]              bus,
  output logic [WIDTH-1:0]              out,
  output logic [$clog2(STACK_DEPTH):0]  sp,
  output logic                          stack_full,
  output logic                          stack_empty,
  output logic                          overflow,
  output logic                          underflow
);

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] stack_top;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             unf_set;

  assign pc_inc = out + WIDTH'(1);

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stack_top),
    .sp    (sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Next-PC selection; everything is gated by pc_enable so X on op/bus is inert
  always_comb begin
    pc_next = out;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (pc_enable) begin
      case (op)
        PC_HOLD:   pc_next = out;
        PC_INC:    pc_next = pc_inc;
        PC_JMP:    pc_next = bus;
        PC_BR_REL: pc_next = cond ? (out + bus) : pc_inc;
        PC_CALL: begin
          pc_next = bus;
          push    = 1'b1;
          ovf_set = stack_full;
        end
        PC_RET: begin
          if (stack_empty) begin
            pc_next = pc_inc;
            unf_set = 1'b1;
          end else begin
            pc_next = stack_top;
            pop     = 1'b1;
          end
        end
        default:   pc_next = pc_inc;
      endcase
    end
  end

  // PC register and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= RESET_VECTOR;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out       <= pc_next;
      overflow  <= overflow | ovf_set;
      underflow <= underflow | unf_set;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random ops
// compared against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [WIDTH-1:0] RV = 16'h0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             pc_enable;
  logic [2:0]       op;
  logic             cond;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] out;
  logic [2:0]       sp;
  logic             stack_full;
  logic             stack_empty;
  logic             overflow;
  logic             underflow;

  pc_sequencer #(
    .WIDTH        (WIDTH),
    .STACK_DEPTH  (DEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_enable   (pc_enable),
    .op          (op),
    .cond        (cond),
    .bus         (bus),
    .out         (out),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stack [$];
  logic             m_ovf;
  logic             m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_apply(input logic r, input logic en, input logic [2:0] o,
                             input logic c, input logic [WIDTH-1:0] b);
    if (r) begin
      m_pc = RV;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (en) begin
      case (o)
        3'd0: ;
        3'd2: m_pc = b;
        3'd3: m_pc = c ? m_pc + b : m_pc + 16'd1;
        3'd4: begin
          if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 16'd1);
          else m_ovf = 1'b1;
          m_pc = b;
        end
        3'd5: begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin
            m_pc  = m_pc + 16'd1;
            m_unf = 1'b1;
          end
        end
        default: m_pc = m_pc + 16'd1;
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out"},   32'(out),         32'(m_pc));
    check({tag, ".sp"},    32'(sp),          32'(m_stack.size()));
    check({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    check({tag, ".ovf"},   32'(overflow),    32'(m_ovf));
    check({tag, ".unf"},   32'(underflow),   32'(m_unf));
  endtask

  // Apply one cycle of stimulus, advance the model, compare after the edge
  task automatic step(input string tag, input logic r, input logic en,
                      input logic [2:0] o, input logic c, input logic [WIDTH-1:0] b);
    rst = r; pc_enable = en; op = o; cond = c; bus = b;
    @(posedge clk);
    #1;
    model_apply(r, en, o, c, b);
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1; pc_enable = 1'b0; op = 3'd0; cond = 1'b0; bus = '0;
    m_pc = RV; m_ovf = 1'b0; m_unf = 1'b0;

    // 1. reset and increment
    step("rst", 1, 0, 3'd0, 0, 16'h0);
    check("t1.reset_pc", 32'(out), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step("t1.inc", 0, 1, 3'd1, 0, 16'h0);
      check("t1.inc_pc", 32'(out), 32'(i));
    end

    // 2. stall, jump, wrap
    step("t2.stall", 0, 0, 3'd2, 0, 16'h1234);
    check("t2.stall_pc", 32'(out), 32'h3);
    step("t2.jmp", 0, 1, 3'd2, 0, 16'h1234);
    check("t2.jmp_pc", 32'(out), 32'h1234);
    step("t2.jmpff", 0, 1, 3'd2, 0, 16'hFFFF);
    step("t2.wrap", 0, 1, 3'd1, 0, 16'h0);
    check("t2.wrap_pc", 32'(out), 32'h0);

    // 3. conditional branch
    step("t3.jmp", 0, 1, 3'd2, 0, 16'h0010);
    step("t3.br1", 0, 1, 3'd3, 1, 16'hFFFC);
    check("t3.br_taken", 32'(out), 32'h000C);
    step("t3.br0", 0, 1, 3'd3, 0, 16'hFFFC);
    check("t3.br_not", 32'(out), 32'h000D);

    // 4. nested calls
    step("t4.jmp", 0, 1, 3'd2, 0, 16'h0100);
    step("t4.call1", 0, 1, 3'd4, 0, 16'h0200);
    step("t4.call2", 0, 1, 3'd4, 0, 16'h0300);
    check("t4.sp2", 32'(sp), 32'd2);
    step("t4.ret1", 0, 1, 3'd5, 0, 16'h0);
    check("t4.ret1_pc", 32'(out), 32'h0201);
    step("t4.ret2", 0, 1, 3'd5, 0, 16'h0);
    check("t4.ret2_pc", 32'(out), 32'h0101);
    check("t4.sp0", 32'(sp), 32'd0);

    // 5. stack boundaries: pushes 0x0102, 0x1001, 0x2001, 0x3001; 5th discarded
    for (int i = 0; i < 5; i++)
      step("t5.call", 0, 1, 3'd4, 0, 16'((i + 1) * 16'h1000));
    check("t5.ovf", 32'(overflow), 32'd1);
    check("t5.sp4", 32'(sp), 32'd4);
    check("t5.out", 32'(out), 32'h5000);
    check("t5.full", 32'(stack_full), 32'd1);
    step("t5.ret", 0, 1, 3'd5, 0, 16'h0);
    check("t5.r1", 32'(out), 32'h3001);
    step("t5.ret", 0, 1, 3'd5, 0, 16'h0);
    check("t5.r2", 32'(out), 32'h2001);
    step("t5.ret", 0, 1, 3'd5, 0, 16'h0);
    check("t5.r3", 32'(out), 32'h1001);
    step("t5.ret", 0, 1, 3'd5, 0, 16'h0);
    check("t5.r4", 32'(out), 32'h0102);
    step("t5.ret", 0, 1, 3'd5, 0, 16'h0);
    check("t5.r5", 32'(out), 32'h0103);
    check("t5.unf", 32'(underflow), 32'd1);

    // 6. reset mid-operation
    step("t6.call", 0, 1, 3'd4, 0, 16'h0400);
    step("t6.call", 0, 1, 3'd4, 0, 16'h0500);
    step("t6.rst", 1, 1, 3'd4, 0, 16'h0600);
    check("t6.rst_pc", 32'(out), 32'(RV));
    check("t6.rst_sp", 32'(sp), 32'd0);
    check("t6.rst_ovf", 32'(overflow), 32'd0);
    step("t6.ret", 0, 1, 3'd5, 0, 16'h0);
    check("t6.unf", 32'(underflow), 32'd1);
    check("t6.ret_pc", 32'(out), 32'(RV + 16'd1));

    // Disabled cycles with garbage on op/bus must not disturb state
    for (int i = 0; i < 8; i++)
      step("hold.x", 0, 0, 3'($urandom), 1'($urandom), 16'($urandom));

    // Randomized ops against the model
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic en;
      r  = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 7) != 0);
      step("rand", r, en, 3'($urandom), 1'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
